// File: rtl/sdram_request_buffer.sv
// Request FIFO between the CPU/GPU requester port and the SDRAM command sequencer.
// Issues one queued request at a time over valid/ready and returns read data on completion.
module sdram_request_buffer #(
   parameter int unsigned ADDR_W = 20,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned PTR_W  = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] sdram_buffer_addr_in,
   input  logic [DATA_W-1:0] sdram_buffer_data_in,
   input  logic              sdram_buffer_rw_in,
   input  logic              sdram_buffer_wrreq,
   output logic [DATA_W-1:0] data_output,
   output logic [ADDR_W-1:0] current_address,
   output logic              sdram_buffer_empty,
   output logic              sdram_buffer_full,
   output logic              overflow,
   output logic              ctrl_req_valid,
   input  logic              ctrl_req_ready,
   output logic [ADDR_W-1:0] ctrl_addr,
   output logic [DATA_W-1:0] ctrl_wdata,
   output logic              ctrl_rw,
   input  logic              ctrl_done,
   input  logic [DATA_W-1:0] ctrl_rdata
);

   typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

   localparam logic [PTR_W:0] CntFull = (PTR_W + 1)'(DEPTH);
   localparam logic [PTR_W:0] CntOne  = (PTR_W + 1)'(1);
   localparam logic [PTR_W-1:0] PtrOne = PTR_W'(1);

   logic [ADDR_W-1:0] r_fifo_addr [DEPTH];
   logic [DATA_W-1:0] r_fifo_data [DEPTH];
   logic              r_fifo_rw   [DEPTH];

   state_e            r_state, w_state_d;
   logic [PTR_W-1:0]  r_wr_ptr, w_wr_ptr_d;
   logic [PTR_W-1:0]  r_rd_ptr, w_rd_ptr_d;
   logic [PTR_W:0]    r_count, w_count_d;
   logic              r_overflow, w_overflow_d;
   logic              r_ctrl_valid, w_ctrl_valid_d;
   logic [ADDR_W-1:0] r_ctrl_addr, w_ctrl_addr_d;
   logic [DATA_W-1:0] r_ctrl_wdata, w_ctrl_wdata_d;
   logic              r_ctrl_rw, w_ctrl_rw_d;
   logic [ADDR_W-1:0] r_lat_addr, w_lat_addr_d;
   logic              r_lat_rw, w_lat_rw_d;
   logic [DATA_W-1:0] r_data_out, w_data_out_d;
   logic [ADDR_W-1:0] r_cur_addr, w_cur_addr_d;

   logic w_full;
   logic w_push;
   logic w_pop;

   // Full is judged on the registered count, so a push while full is dropped even if a pop
   // happens on the same edge.
   assign w_full = (r_count == CntFull);
   assign w_push = sdram_buffer_wrreq && !w_full;
   assign w_pop  = (r_state == StIssue) && r_ctrl_valid && ctrl_req_ready;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_addr[r_wr_ptr] <= sdram_buffer_addr_in;
         r_fifo_data[r_wr_ptr] <= sdram_buffer_data_in;
         r_fifo_rw[r_wr_ptr]   <= sdram_buffer_rw_in;
      end
   end

   always_comb begin
      w_state_d      = r_state;
      w_wr_ptr_d     = r_wr_ptr;
      w_rd_ptr_d     = r_rd_ptr;
      w_count_d      = r_count;
      w_overflow_d   = r_overflow;
      w_ctrl_valid_d = r_ctrl_valid;
      w_ctrl_addr_d  = r_ctrl_addr;
      w_ctrl_wdata_d = r_ctrl_wdata;
      w_ctrl_rw_d    = r_ctrl_rw;
      w_lat_addr_d   = r_lat_addr;
      w_lat_rw_d     = r_lat_rw;
      w_data_out_d   = r_data_out;
      w_cur_addr_d   = r_cur_addr;

      if (sdram_buffer_wrreq && w_full) begin
         w_overflow_d = 1'b1;
      end
      if (w_push) begin
         w_wr_ptr_d = r_wr_ptr + PtrOne;
      end
      if (w_pop) begin
         w_rd_ptr_d = r_rd_ptr + PtrOne;
      end
      case ({w_push, w_pop})
         2'b10:   w_count_d = r_count + CntOne;
         2'b01:   w_count_d = r_count - CntOne;
         default: w_count_d = r_count;
      endcase

      unique case (r_state)
         StIdle: begin
            if (r_count != '0) begin
               w_ctrl_addr_d  = r_fifo_addr[r_rd_ptr];
               w_ctrl_wdata_d = r_fifo_data[r_rd_ptr];
               w_ctrl_rw_d    = r_fifo_rw[r_rd_ptr];
               w_ctrl_valid_d = 1'b1;
               w_state_d      = StIssue;
            end
         end
         StIssue: begin
            if (w_pop) begin
               w_ctrl_valid_d = 1'b0;
               w_lat_addr_d   = r_ctrl_addr;
               w_lat_rw_d     = r_ctrl_rw;
               w_state_d      = StWait;
            end
         end
         StWait: begin
            if (ctrl_done) begin
               w_cur_addr_d = r_lat_addr;
               if (!r_lat_rw) begin
                  w_data_out_d = ctrl_rdata;
               end
               w_state_d = StIdle;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= StIdle;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_overflow   <= 1'b0;
         r_ctrl_valid <= 1'b0;
         r_ctrl_addr  <= '0;
         r_ctrl_wdata <= '0;
         r_ctrl_rw    <= 1'b0;
         r_lat_addr   <= '0;
         r_lat_rw     <= 1'b0;
         r_data_out   <= '0;
         r_cur_addr   <= '0;
      end else begin
         r_state      <= w_state_d;
         r_wr_ptr     <= w_wr_ptr_d;
         r_rd_ptr     <= w_rd_ptr_d;
         r_count      <= w_count_d;
         r_overflow   <= w_overflow_d;
         r_ctrl_valid <= w_ctrl_valid_d;
         r_ctrl_addr  <= w_ctrl_addr_d;
         r_ctrl_wdata <= w_ctrl_wdata_d;
         r_ctrl_rw    <= w_ctrl_rw_d;
         r_lat_addr   <= w_lat_addr_d;
         r_lat_rw     <= w_lat_rw_d;
         r_data_out   <= w_data_out_d;
         r_cur_addr   <= w_cur_addr_d;
      end
   end

   assign sdram_buffer_full  = w_full;
   assign sdram_buffer_empty = (r_count == '0) && (r_state == StIdle);
   assign overflow           = r_overflow;
   assign ctrl_req_valid     = r_ctrl_valid;
   assign ctrl_addr          = r_ctrl_addr;
   assign ctrl_wdata         = r_ctrl_wdata;
   assign ctrl_rw            = r_ctrl_rw;
   assign data_output        = r_data_out;
   assign current_address    = r_cur_addr;

endmodule

// File: tb/tb_sdram_request_buffer.sv
// Directed bench for sdram_request_buffer: the bench plays the SDRAM controller by hand
// and checks issue order, returned data, flags and reset behaviour.
module tb_sdram_request_buffer;

   logic        clk;
   logic        reset;
   logic [19:0] addr_in;
   logic [15:0] data_in;
   logic        rw_in;
   logic        wrreq;
   logic [15:0] data_output;
   logic [19:0] current_address;
   logic        empty;
   logic        full;
   logic        overflow;
   logic        ctrl_req_valid;
   logic        ctrl_req_ready;
   logic [19:0] ctrl_addr;
   logic [15:0] ctrl_wdata;
   logic        ctrl_rw;
   logic        ctrl_done;
   logic [15:0] ctrl_rdata;

   int checks = 0;
   int errors = 0;

   sdram_request_buffer #(
      .ADDR_W (20),
      .DATA_W (16),
      .DEPTH  (4),
      .PTR_W  (2)
   ) dut (
      .clk                  (clk),
      .reset                (reset),
      .sdram_buffer_addr_in (addr_in),
      .sdram_buffer_data_in (data_in),
      .sdram_buffer_rw_in   (rw_in),
      .sdram_buffer_wrreq   (wrreq),
      .data_output          (data_output),
      .current_address      (current_address),
      .sdram_buffer_empty   (empty),
      .sdram_buffer_full    (full),
      .overflow             (overflow),
      .ctrl_req_valid       (ctrl_req_valid),
      .ctrl_req_ready       (ctrl_req_ready),
      .ctrl_addr            (ctrl_addr),
      .ctrl_wdata           (ctrl_wdata),
      .ctrl_rw              (ctrl_rw),
      .ctrl_done            (ctrl_done),
      .ctrl_rdata           (ctrl_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge; outputs are then settled and inputs may be changed.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Wait for a request, accept it (optionally pushing on the same edge), then complete it
   // as a read whose data is derived from the address.
   task automatic serve_read(input logic [19:0] exp_addr, input logic push_en,
                             input logic [19:0] push_addr);
      int n = 0;
      logic [15:0] rdata;
      while (!ctrl_req_valid && n < 20) begin
         step();
         n++;
      end
      check_eq("issue_valid", 32'(ctrl_req_valid), 32'd1);
      check_eq("issue_addr", 32'(ctrl_addr), 32'(exp_addr));
      check_eq("issue_rw", 32'(ctrl_rw), 32'd0);
      ctrl_req_ready = 1'b1;
      if (push_en) begin
         addr_in = push_addr;
         data_in = 16'h0;
         rw_in   = 1'b0;
         wrreq   = 1'b1;
      end
      step();
      wrreq = 1'b0;
      check_eq("pop_valid_drop", 32'(ctrl_req_valid), 32'd0);
      check_eq("pop_not_full", 32'(full), 32'd0);
      rdata      = 16'hA000 | 16'(exp_addr[11:0]);
      ctrl_done  = 1'b1;
      ctrl_rdata = rdata;
      step();
      ctrl_done = 1'b0;
      check_eq("done_data", 32'(data_output), 32'(rdata));
      check_eq("done_addr", 32'(current_address), 32'(exp_addr));
   endtask

   initial begin
      reset          = 1'b0;
      addr_in        = '0;
      data_in        = '0;
      rw_in          = 1'b0;
      wrreq          = 1'b0;
      ctrl_req_ready = 1'b0;
      ctrl_done      = 1'b0;
      ctrl_rdata     = '0;

      // Reset state
      step();
      step();
      check_eq("rst_empty", 32'(empty), 32'd1);
      check_eq("rst_full", 32'(full), 32'd0);
      check_eq("rst_valid", 32'(ctrl_req_valid), 32'd0);
      check_eq("rst_overflow", 32'(overflow), 32'd0);
      check_eq("rst_data", 32'(data_output), 32'd0);
      check_eq("rst_addr", 32'(current_address), 32'd0);
      reset = 1'b1;
      step();

      // Reset while a request is outstanding and another is queued
      ctrl_req_ready = 1'b1;
      addr_in = 20'h00A00; wrreq = 1'b1;
      step();
      addr_in = 20'h00A01;
      step();
      wrreq = 1'b0;
      step();
      check_eq("midwait_not_empty", 32'(empty), 32'd0);
      ctrl_req_ready = 1'b0;
      #2 reset = 1'b0;
      #1;
      check_eq("async_rst_empty", 32'(empty), 32'd1);
      check_eq("async_rst_full", 32'(full), 32'd0);
      check_eq("async_rst_valid", 32'(ctrl_req_valid), 32'd0);
      check_eq("async_rst_overflow", 32'(overflow), 32'd0);
      step();
      reset = 1'b1;
      ctrl_done = 1'b1; ctrl_rdata = 16'hDEAD;
      step();
      ctrl_done = 1'b0;
      check_eq("stale_done_data", 32'(data_output), 32'd0);
      check_eq("stale_done_addr", 32'(current_address), 32'd0);
      check_eq("stale_done_empty", 32'(empty), 32'd1);
      step();
      check_eq("stale_done_no_issue", 32'(ctrl_req_valid), 32'd0);

      // Single read
      ctrl_req_ready = 1'b1;
      addr_in = 20'h00010; rw_in = 1'b0; data_in = 16'h0; wrreq = 1'b1;
      step();
      wrreq = 1'b0;
      check_eq("rd_valid_lat0", 32'(ctrl_req_valid), 32'd0);
      check_eq("rd_not_empty", 32'(empty), 32'd0);
      step();
      check_eq("rd_valid", 32'(ctrl_req_valid), 32'd1);
      check_eq("rd_addr", 32'(ctrl_addr), 32'h00010);
      check_eq("rd_rw", 32'(ctrl_rw), 32'd0);
      step();
      check_eq("rd_valid_one_cycle", 32'(ctrl_req_valid), 32'd0);
      step();
      step();
      check_eq("rd_wait_not_empty", 32'(empty), 32'd0);
      ctrl_done = 1'b1; ctrl_rdata = 16'hBEEF;
      step();
      ctrl_done = 1'b0;
      check_eq("rd_data", 32'(data_output), 32'hBEEF);
      check_eq("rd_cur_addr", 32'(current_address), 32'h00010);
      check_eq("rd_empty", 32'(empty), 32'd1);

      // Write then read to the same address
      addr_in = 20'h00020; data_in = 16'h1234; rw_in = 1'b1; wrreq = 1'b1;
      step();
      addr_in = 20'h00020; data_in = 16'h0; rw_in = 1'b0;
      step();
      wrreq = 1'b0;
      check_eq("wr_valid", 32'(ctrl_req_valid), 32'd1);
      check_eq("wr_addr", 32'(ctrl_addr), 32'h00020);
      check_eq("wr_rw", 32'(ctrl_rw), 32'd1);
      check_eq("wr_wdata", 32'(ctrl_wdata), 32'h1234);
      step();
      check_eq("wr_popped", 32'(ctrl_req_valid), 32'd0);
      ctrl_done = 1'b1; ctrl_rdata = 16'h5555;
      step();
      ctrl_done = 1'b0;
      check_eq("wr_cur_addr", 32'(current_address), 32'h00020);
      check_eq("wr_data_kept", 32'(data_output), 32'hBEEF);
      step();
      check_eq("wr_rd_valid", 32'(ctrl_req_valid), 32'd1);
      check_eq("wr_rd_rw", 32'(ctrl_rw), 32'd0);
      check_eq("wr_rd_addr", 32'(ctrl_addr), 32'h00020);
      step();
      ctrl_done = 1'b1; ctrl_rdata = 16'h1234;
      step();
      ctrl_done = 1'b0;
      check_eq("wr_rd_data", 32'(data_output), 32'h1234);
      check_eq("wr_rd_empty", 32'(empty), 32'd1);

      // Backpressure: fill, drop the fifth, then drain in order
      ctrl_req_ready = 1'b0;
      rw_in = 1'b0; data_in = 16'h0;
      for (int i = 0; i < 5; i++) begin
         addr_in = 20'h00100 + 20'(i);
         wrreq   = 1'b1;
         step();
         if (i == 3) begin
            check_eq("bp_full_after4", 32'(full), 32'd1);
            check_eq("bp_no_overflow_yet", 32'(overflow), 32'd0);
         end
      end
      wrreq = 1'b0;
      check_eq("bp_full", 32'(full), 32'd1);
      check_eq("bp_overflow", 32'(overflow), 32'd1);
      check_eq("bp_valid", 32'(ctrl_req_valid), 32'd1);
      check_eq("bp_addr_stable", 32'(ctrl_addr), 32'h00100);
      for (int i = 0; i < 4; i++) begin
         serve_read(20'h00100 + 20'(i), 1'b0, 20'h0);
      end
      step();
      check_eq("bp_drained_empty", 32'(empty), 32'd1);
      check_eq("bp_overflow_sticky", 32'(overflow), 32'd1);

      // Simultaneous push/pop at count 3, nine requests across pointer wrap
      ctrl_req_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         addr_in = 20'h00200 + 20'(i);
         wrreq   = 1'b1;
         step();
      end
      wrreq = 1'b0;
      check_eq("sim_not_full_at3", 32'(full), 32'd0);
      for (int i = 0; i < 9; i++) begin
         serve_read(20'h00200 + 20'(i), (i < 6), 20'h00203 + 20'(i));
      end
      step();
      check_eq("sim_drained_empty", 32'(empty), 32'd1);
      check_eq("sim_no_new_issue", 32'(ctrl_req_valid), 32'd0);

      // Spurious done while idle and empty
      ctrl_done = 1'b1; ctrl_rdata = 16'h7777;
      step();
      ctrl_done = 1'b0;
      check_eq("spur_data", 32'(data_output), 32'hA208);
      check_eq("spur_addr", 32'(current_address), 32'h00208);
      check_eq("spur_empty", 32'(empty), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
